acq_control_regfile: RTL and testbench

//  Parametrised control register bank behind the regaccess SPI slave: decodes reg_num/reg_write,

---
 rtl/acq_control_regfile.sv | 160 ++++++++++++++++
 tb/tb_acq_control_regfile.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/acq_control_regfile.sv
// Control register bank behind the regaccess SPI slave: double-buffered acquisition
// config, start/stop sequencing FSM, sticky W1C overflow flag and LED PWM.
module acq_control_regfile #(
   parameter int         NUM_CHANNELS  = 16,
   parameter int         DIV_WIDTH     = 8,
   parameter logic [7:0] VERSION       = 8'h11,
   parameter logic [7:0] SCRATCH_RESET = 8'h73,
   parameter int         PWM_WIDTH     = 18
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [6:0]              reg_num,
   input  logic                    reg_write,
   input  logic [7:0]              reg_data_write,
   output logic [7:0]              reg_data_read,
   input  logic                    acq_overflow,
   input  logic                    acq_stopped,
   output logic                    acq_enable,
   output logic                    clock_select,
   output logic [DIV_WIDTH-1:0]    clock_divisor,
   output logic [NUM_CHANNELS-1:0] channel_enable,
   output logic                    led_out
);

   localparam int         NUM_BYTES   = NUM_CHANNELS / 8;
   localparam logic [6:0] ADDR_VERSION = 7'h00;
   localparam logic [6:0] ADDR_STATUS  = 7'h01;
   localparam logic [6:0] ADDR_DIV_LO  = 7'h04;
   localparam logic [6:0] ADDR_LED     = 7'h05;
   localparam logic [6:0] ADDR_MODE    = 7'h0A;
   localparam logic [6:0] ADDR_SCRATCH = 7'h0D;
   localparam logic [6:0] ADDR_DIV_HI  = 7'h0E;

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_STOP} state_t;

   state_t                  r_state;
   state_t                  w_state_next;
   logic                    r_acq_req;
   logic                    r_overflow;
   logic                    r_user_bit;
   logic [DIV_WIDTH-1:0]    r_div_shadow;
   logic                    r_clk_sel_shadow;
   logic [NUM_CHANNELS-1:0] r_chan_shadow;
   logic [7:0]              r_brightness;
   logic [7:0]              r_scratch;
   logic                    r_clock_select;
   logic [DIV_WIDTH-1:0]    r_clock_divisor;
   logic [NUM_CHANNELS-1:0] r_channel_enable;
   logic [PWM_WIDTH-1:0]    r_pwm_cnt;
   logic [15:0]             w_div_wide;
   logic [15:0]             w_div_ext;
   logic                    w_running;

   assign w_running = (r_state == ST_RUN);
   assign w_div_ext = 16'(r_div_shadow);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (r_acq_req && acq_stopped)     w_state_next = ST_LOAD;
         ST_LOAD:                                   w_state_next = ST_RUN;
         ST_RUN:  if (!r_acq_req || acq_overflow)   w_state_next = ST_STOP;
         ST_STOP: if (acq_stopped)                  w_state_next = ST_IDLE;
         default:                                   w_state_next = ST_IDLE;
      endcase
   end

   // Byte-wide view of the divisor shadow so either half can be replaced, then truncated back.
   always_comb begin
      w_div_wide = w_div_ext;
      if (reg_num == ADDR_DIV_LO)      w_div_wide[7:0]  = reg_data_write;
      else if (reg_num == ADDR_DIV_HI) w_div_wide[15:8] = reg_data_write;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acq_req        <= 1'b0;
         r_user_bit       <= 1'b0;
         r_div_shadow     <= '0;
         r_clk_sel_shadow <= 1'b0;
         r_chan_shadow    <= '0;
         r_brightness     <= 8'h00;
         r_scratch        <= SCRATCH_RESET;
      end else begin
         if (reg_write) begin
            case (reg_num)
               ADDR_STATUS: begin
                  r_acq_req  <= reg_data_write[0];
                  r_user_bit <= reg_data_write[6];
               end
               ADDR_DIV_LO, ADDR_DIV_HI: r_div_shadow     <= DIV_WIDTH'(w_div_wide);
               ADDR_LED:                 r_brightness     <= reg_data_write;
               ADDR_MODE:                r_clk_sel_shadow <= reg_data_write[0];
               ADDR_SCRATCH:             r_scratch        <= reg_data_write;
               default: begin
                  for (int k = 0; k < NUM_BYTES; k++)
                     if (reg_num == 7'(16 + k)) r_chan_shadow[k*8 +: 8] <= reg_data_write;
               end
            endcase
         end
         // An overflow during a run withdraws the request, overriding a same-cycle host write.
         if (acq_overflow && w_running) r_acq_req <= 1'b0;
      end
   end

   // Sticky flag: a fresh overflow pulse beats a simultaneous write-1-to-clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                              r_overflow <= 1'b0;
      else if (acq_overflow)                                r_overflow <= 1'b1;
      else if (reg_write && reg_num == ADDR_STATUS && reg_data_write[2]) r_overflow <= 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_clock_select   <= 1'b0;
         r_clock_divisor  <= '0;
         r_channel_enable <= '0;
      end else if (r_state == ST_LOAD) begin
         r_clock_select   <= r_clk_sel_shadow;
         r_clock_divisor  <= r_div_shadow;
         r_channel_enable <= r_chan_shadow;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_pwm_cnt <= '0;
      else     r_pwm_cnt <= r_pwm_cnt + PWM_WIDTH'(1);
   end

   always_comb begin
      reg_data_read = 8'h00;
      case (reg_num)
         ADDR_VERSION: reg_data_read = VERSION;
         ADDR_STATUS:  reg_data_read = {1'b0, r_user_bit, 3'b000, r_overflow, w_running, r_acq_req};
         ADDR_DIV_LO:  reg_data_read = w_div_ext[7:0];
         ADDR_DIV_HI:  reg_data_read = w_div_ext[15:8];
         ADDR_LED:     reg_data_read = r_brightness;
         ADDR_MODE:    reg_data_read = {7'b0000000, r_clk_sel_shadow};
         ADDR_SCRATCH: reg_data_read = r_scratch;
         default: begin
            for (int k = 0; k < NUM_BYTES; k++)
               if (reg_num == 7'(16 + k)) reg_data_read = r_chan_shadow[k*8 +: 8];
         end
      endcase
   end

   assign acq_enable     = w_running;
   assign clock_select   = r_clock_select;
   assign clock_divisor  = r_clock_divisor;
   assign channel_enable = r_channel_enable;
   assign led_out        = ~(r_pwm_cnt[PWM_WIDTH-1 -: 8] < r_brightness);

endmodule

// File: tb/tb_acq_control_regfile.sv
// Self-checking bench for acq_control_regfile: directed steps plus randomized register
// traffic, checked against a cycle-level behavioural model of the register map.
module tb_acq_control_regfile;

   localparam int NCH   = 16;
   localparam int DW    = 8;
   localparam int PW    = 10;
   localparam int NB    = NCH / 8;
   localparam int DMASK = (1 << DW) - 1;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [6:0]     reg_num = '0;
   logic           reg_write = 1'b0;
   logic [7:0]     reg_data_write = '0;
   logic [7:0]     reg_data_read;
   logic           acq_overflow = 1'b0;
   logic           acq_stopped = 1'b1;
   logic           acq_enable;
   logic           clock_select;
   logic [DW-1:0]  clock_divisor;
   logic [NCH-1:0] channel_enable;
   logic           led_out;

   always #5 clk = ~clk;

   acq_control_regfile #(
      .NUM_CHANNELS(NCH), .DIV_WIDTH(DW), .VERSION(8'h11),
      .SCRATCH_RESET(8'h73), .PWM_WIDTH(PW)
   ) dut (
      .clk(clk), .rst(rst), .reg_num(reg_num), .reg_write(reg_write),
      .reg_data_write(reg_data_write), .reg_data_read(reg_data_read),
      .acq_overflow(acq_overflow), .acq_stopped(acq_stopped), .acq_enable(acq_enable),
      .clock_select(clock_select), .clock_divisor(clock_divisor),
      .channel_enable(channel_enable), .led_out(led_out)
   );

   int tests = 0;
   int fails = 0;

   // Behavioural model: phase name, host-visible register contents, active config.
   string          m_phase;
   bit             m_req, m_ovf, m_user, m_sel, m_act_sel;
   int             m_div, m_act_div, m_tick;
   logic [7:0]     m_bright, m_scratch;
   logic [7:0]     m_chan [NB];
   logic [NCH-1:0] m_act_chan;

   logic [6:0] pool [11] = '{7'h00, 7'h01, 7'h04, 7'h05, 7'h0A, 7'h0D, 7'h0E,
                             7'h10, 7'h11, 7'h12, 7'h7F};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = "IDLE";
      m_req = 0; m_ovf = 0; m_user = 0; m_sel = 0; m_act_sel = 0;
      m_div = 0; m_act_div = 0; m_tick = 0;
      m_bright = 8'h00; m_scratch = 8'h73; m_act_chan = '0;
      for (int k = 0; k < NB; k++) m_chan[k] = 8'h00;
   endtask

   function automatic logic [7:0] exp_read(input int num);
      if (num == 'h00) return 8'h11;
      if (num == 'h01) return {1'b0, m_user, 3'b000, m_ovf, m_phase == "RUN", m_req};
      if (num == 'h04) return 8'(m_div % 256);
      if (num == 'h0E) return 8'(m_div / 256);
      if (num == 'h05) return m_bright;
      if (num == 'h0A) return {7'b0, m_sel};
      if (num == 'h0D) return m_scratch;
      if (num >= 'h10 && num < 'h10 + NB) return m_chan[num - 'h10];
      return 8'h00;
   endfunction

   task automatic model_step(input bit wr, input int num, input logic [7:0] d,
                             input bit ovf, input bit stp);
      bit    was_run = (m_phase == "RUN");
      string nxt = m_phase;
      if (m_phase == "IDLE") begin
         if (m_req && stp) nxt = "LOAD";
      end else if (m_phase == "LOAD") begin
         m_act_sel = m_sel;
         m_act_div = m_div;
         for (int k = 0; k < NB; k++) m_act_chan[k*8 +: 8] = m_chan[k];
         nxt = "RUN";
      end else if (m_phase == "RUN") begin
         if (!m_req || ovf) nxt = "STOP";
      end else begin
         if (stp) nxt = "IDLE";
      end
      if (wr) begin
         if (num == 'h01) begin
            m_req = d[0]; m_user = d[6];
            if (d[2]) m_ovf = 0;
         end
         else if (num == 'h04) m_div = ((m_div & ~255) | int'(d)) & DMASK;
         else if (num == 'h0E) m_div = ((m_div & 255) | (int'(d) << 8)) & DMASK;
         else if (num == 'h05) m_bright = d;
         else if (num == 'h0A) m_sel = d[0];
         else if (num == 'h0D) m_scratch = d;
         else if (num >= 'h10 && num < 'h10 + NB) m_chan[num - 'h10] = d;
      end
      if (ovf) begin
         m_ovf = 1;
         if (was_run) m_req = 0;
      end
      m_phase = nxt;
      m_tick++;
   endtask

   task automatic check_outputs(input int num);
      int level = (m_tick % (1 << PW)) >> (PW - 8);
      check("acq_enable", acq_enable, m_phase == "RUN");
      check("clock_select", clock_select, m_act_sel);
      check("clock_divisor", clock_divisor, m_act_div);
      check("channel_enable", channel_enable, m_act_chan);
      check("led_out", led_out, (level < int'(m_bright)) ? 0 : 1);
      check($sformatf("read_%02h", num), reg_data_read, exp_read(num));
   endtask

   // One clock: drive at negedge, model the edge, compare 1 ns after it, return at negedge.
   task automatic cycle(input bit wr, input logic [6:0] num, input logic [7:0] d,
                        input bit ovf, input bit stp);
      reg_write = wr; reg_num = num; reg_data_write = d;
      acq_overflow = ovf; acq_stopped = stp;
      @(posedge clk);
      model_step(wr, int'(num), d, ovf, stp);
      #1;
      reg_write = 1'b0; acq_overflow = 1'b0;
      check_outputs(int'(num));
      @(negedge clk);
   endtask

   task automatic read_check(input string tag, input logic [6:0] num, input logic [7:0] exp);
      reg_num = num;
      #1;
      check(tag, reg_data_read, exp);
   endtask

   initial begin
      int lows;
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_acq_enable", acq_enable, 0);
      check("rst_led_out", led_out, 1);
      rst = 1'b0;
      read_check("rst_version", 7'h00, 8'h11);
      read_check("rst_scratch", 7'h0D, 8'h73);
      read_check("rst_status", 7'h01, 8'h00);
      check("rst_channel_enable", channel_enable, 0);
      check("rst_clock_divisor", clock_divisor, 0);
      check("rst_clock_select", clock_select, 0);

      // Configure and start; enable rises two cycles after the request write.
      cycle(1, 7'h10, 8'hA5, 0, 1);
      cycle(1, 7'h11, 8'h3C, 0, 1);
      cycle(1, 7'h04, 8'h07, 0, 1);
      cycle(1, 7'h01, 8'h01, 0, 1);
      cycle(0, 7'h01, 8'h00, 0, 1);
      check("load_not_yet_enabled", acq_enable, 0);
      cycle(0, 7'h01, 8'h00, 0, 1);
      check("start_acq_enable", acq_enable, 1);
      check("start_channel_enable", channel_enable, 16'h3CA5);
      check("start_divisor", clock_divisor, 7);
      check("start_status", reg_data_read, 8'h03);

      // Shadow write during a run stays invisible until the next start.
      cycle(1, 7'h10, 8'hFF, 0, 1);
      check("run_shadow_hidden", channel_enable, 16'h3CA5);
      check("run_shadow_read", reg_data_read, 8'hFF);
      cycle(1, 7'h01, 8'h00, 0, 1);
      repeat (3) cycle(0, 7'h01, 8'h00, 0, 1);
      cycle(1, 7'h01, 8'h01, 0, 1);
      repeat (2) cycle(0, 7'h01, 8'h00, 0, 1);
      check("restart_channel_enable", channel_enable, 16'h3CFF);
      check("restart_acq_enable", acq_enable, 1);

      // Overflow in a run: stop next cycle, request cleared, flag set; STOP waits for acq_stopped.
      cycle(0, 7'h01, 8'h00, 1, 0);
      check("ovf_acq_enable", acq_enable, 0);
      check("ovf_status", reg_data_read, 8'h04);
      repeat (3) cycle(0, 7'h01, 8'h00, 0, 0);
      check("stop_hold_enable", acq_enable, 0);
      cycle(1, 7'h01, 8'h04, 0, 0);
      check("w1c_status", reg_data_read, 8'h00);
      cycle(1, 7'h01, 8'h01, 0, 0);
      repeat (3) cycle(0, 7'h01, 8'h00, 0, 1);
      check("auto_restart_enable", acq_enable, 1);
      cycle(1, 7'h01, 8'h00, 0, 1);
      repeat (3) cycle(0, 7'h01, 8'h00, 0, 1);

      // Overflow pulse coincident with W1C: set wins.
      cycle(1, 7'h01, 8'h04, 1, 1);
      check("ovf_vs_w1c", reg_data_read, 8'h04);
      cycle(1, 7'h01, 8'h04, 0, 1);

      // Unmapped addresses and bits beyond the register widths.
      cycle(1, 7'h0E, 8'h55, 0, 1);
      check("div_hi_reads_zero", reg_data_read, 8'h00);
      cycle(1, 7'h12, 8'hAA, 0, 1);
      check("unmapped_reads_zero", reg_data_read, 8'h00);
      cycle(1, 7'h0A, 8'hFF, 0, 1);
      check("mode_bit0_only", reg_data_read, 8'h01);
      cycle(1, 7'h00, 8'h5A, 0, 1);
      check("version_read_only", reg_data_read, 8'h11);

      // Half brightness: LED low for exactly half of one PWM period.
      cycle(1, 7'h05, 8'h80, 0, 1);
      lows = 0;
      for (int i = 0; i < (1 << PW); i++) begin
         cycle(0, 7'h00, 8'h00, 0, 1);
         if (led_out == 1'b0) lows++;
      end
      check("led_low_count", lows, 512);

      // Randomized register traffic, overflow pulses and sampler handshakes.
      for (int i = 0; i < 400; i++) begin
         logic [6:0] a = pool[$urandom_range(0, 10)];
         cycle(($urandom_range(0, 2) == 0), a, 8'($urandom),
               ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
      end

      // Reset in the middle of a run drops everything before the next edge.
      cycle(1, 7'h01, 8'h01, 0, 1);
      repeat (4) cycle(0, 7'h01, 8'h00, 0, 1);
      check("pre_reset_running", acq_enable, 1);
      rst = 1'b1;
      #1;
      check("async_rst_acq_enable", acq_enable, 0);
      check("async_rst_channel_enable", channel_enable, 0);
      check("async_rst_led_out", led_out, 1);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      cycle(0, 7'h0D, 8'h00, 0, 1);
      cycle(0, 7'h01, 8'h00, 0, 1);
      check("post_reset_status", reg_data_read, 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
